// File: rtl/cache_controller_pkg.sv
// cache_controller_pkg: shared FSM state encoding and default geometry for the two-way cache.
package cache_controller_pkg;
    localparam int ADDRESS_LEN_DEF = 32;
    localparam int DATA_LEN_DEF    = 32;
    localparam int SET_BITS_DEF    = 6;
    localparam int TAG_BITS_DEF    = 10;
    localparam int CACHE_WAYS      = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RD_MISS = 2'b01,
        WR_THRU = 2'b10
    } state_t;
endpackage

// File: rtl/cache_way.sv
// cache_way: one way of the set-associative cache (valid, tag and data arrays).
// Ports: clk/rst (async active-low, clears valid bits only), index/tag select and
// compare the set (combinational hit, valid and read_data), write_en/write_data
// store tag+data into the selected set and mark it valid on the rising edge.
module cache_way #(
    parameter int SET_BITS = 6,
    parameter int TAG_BITS = 10,
    parameter int DATA_LEN = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SET_BITS-1:0] index,
    input  logic [TAG_BITS-1:0] tag,
    input  logic                write_en,
    input  logic [DATA_LEN-1:0] write_data,
    output logic                hit,
    output logic                valid,
    output logic [DATA_LEN-1:0] read_data
);
    localparam int SETS = 1 << SET_BITS;

    logic [SETS-1:0]     valid_bits;
    logic [TAG_BITS-1:0] tags [SETS];
    logic [DATA_LEN-1:0] data [SETS];

    assign valid     = valid_bits[index];
    assign hit       = valid && (tags[index] == tag);
    assign read_data = data[index];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            valid_bits <= '0;
        else if (write_en)
            valid_bits[index] <= 1'b1;
    end

    // Tag and data storage carry no reset; the valid bits gate them.
    always_ff @(posedge clk) begin
        if (write_en) begin
            tags[index] <= tag;
            data[index] <= write_data;
        end
    end
endmodule

// File: rtl/cache_controller.sv
// cache_controller: two-way set-associative, write-through, no-write-allocate data cache
// between the memory stage and the SRAM controller.
// Ports: clk, rst (async active-low); mem_read_en/mem_write_en/mem_address/mem_write_data
// from the pipeline, mem_read_data/ready (0 freezes the pipeline) back to it;
// sram_read_en/sram_write_en/sram_address/sram_write_data to the SRAM controller,
// sram_read_data/sram_ready from it.
// Optional feature CACHE_STATS_EN adds saturating 16-bit hit_count/miss_count outputs.
module cache_controller
    import cache_controller_pkg::*;
#(
    parameter int ADDRESS_LEN = ADDRESS_LEN_DEF,
    parameter int DATA_LEN    = DATA_LEN_DEF,
    parameter int SET_BITS    = SET_BITS_DEF,
    parameter int TAG_BITS    = TAG_BITS_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mem_read_en,
    input  logic                   mem_write_en,
    input  logic [ADDRESS_LEN-1:0] mem_address,
    input  logic [DATA_LEN-1:0]    mem_write_data,
    output logic [DATA_LEN-1:0]    mem_read_data,
    output logic                   ready,
    output logic                   sram_read_en,
    output logic                   sram_write_en,
    output logic [ADDRESS_LEN-1:0] sram_address,
    output logic [DATA_LEN-1:0]    sram_write_data,
    input  logic [DATA_LEN-1:0]    sram_read_data,
    input  logic                   sram_ready
`ifdef CACHE_STATS_EN
    ,
    output logic [15:0]            hit_count,
    output logic [15:0]            miss_count
`endif
);
    localparam int SETS = 1 << SET_BITS;

    state_t                  state;
    logic [ADDRESS_LEN-1:0]  req_addr, lookup_addr;
    logic [DATA_LEN-1:0]     req_data, hit_data, fill_data;
    logic [SETS-1:0]         lru;
    logic [CACHE_WAYS-1:0]   hit_w, valid_w, we_w;
    logic [DATA_LEN-1:0]     data_w [CACHE_WAYS];
    logic [SET_BITS-1:0]     index;
    logic [TAG_BITS-1:0]     tag;
    logic idle, rd, wr, hit, hit_way, victim, done, lru_en, lru_val, unused_bits;

    // Requests are masked while reset is held so the outputs show an idle cache.
    assign idle = state == IDLE;
    assign rd   = rst && mem_read_en;
    assign wr   = rst && mem_write_en && !mem_read_en;
    assign done = !idle && sram_ready;

    // After IDLE the lookup runs on the latched request, which also addresses fills.
    assign lookup_addr = idle ? mem_address : req_addr;
    assign index       = lookup_addr[SET_BITS+1:2];
    assign tag         = lookup_addr[SET_BITS+TAG_BITS+1:SET_BITS+2];
    assign unused_bits = ^{lookup_addr[1:0], lookup_addr[ADDRESS_LEN-1:SET_BITS+TAG_BITS+2]};

    assign hit      = |hit_w;
    assign hit_way  = hit_w[1];
    assign hit_data = data_w[hit_way];
    assign victim   = !valid_w[0] ? 1'b0 : !valid_w[1] ? 1'b1 : lru[index];
    assign fill_data = state == RD_MISS ? sram_read_data : req_data;

    for (genvar g = 0; g < CACHE_WAYS; g++) begin : g_way
        // Read misses fill the victim; write-throughs only refresh a way that already hits.
        assign we_w[g] = done && (state == RD_MISS ? victim == 1'(g) : hit_w[g]);
        cache_way #(
            .SET_BITS (SET_BITS),
            .TAG_BITS (TAG_BITS),
            .DATA_LEN (DATA_LEN)
        ) u_way (
            .clk        (clk),
            .rst        (rst),
            .index      (index),
            .tag        (tag),
            .write_en   (we_w[g]),
            .write_data (fill_data),
            .hit        (hit_w[g]),
            .valid      (valid_w[g]),
            .read_data  (data_w[g])
        );
    end

    assign ready           = idle ? (rd ? hit : !wr) : sram_ready;
    assign mem_read_data   = idle ? (rd && hit ? hit_data : '0)
                                  : (state == RD_MISS && sram_ready ? sram_read_data : '0);
    assign sram_read_en    = idle ? rd && !hit : state == RD_MISS;
    assign sram_write_en   = idle ? wr : state == WR_THRU;
    assign sram_address    = idle ? mem_address : req_addr;
    assign sram_write_data = idle ? mem_write_data : req_data;

    // The LRU bit names the way to evict next, so it points away from the way just used.
    assign lru_en  = idle ? rd && hit : done && (state == RD_MISS || hit);
    assign lru_val = state == RD_MISS ? !victim : !hit_way;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            req_addr <= '0;
            req_data <= '0;
            lru      <= '0;
        end else begin
            if (lru_en)
                lru[index] <= lru_val;
            if (idle && (rd || wr)) begin
                req_addr <= mem_address;
                req_data <= mem_write_data;
            end
            state <= idle ? (rd && !hit ? RD_MISS : wr ? WR_THRU : IDLE)
                          : (sram_ready ? IDLE : state);
        end
    end

`ifdef CACHE_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (idle && rd) begin
            if (hit && hit_count != 16'hFFFF)
                hit_count <= hit_count + 16'd1;
            if (!hit && miss_count != 16'hFFFF)
                miss_count <= miss_count + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_cache_controller.sv
// tb_cache_controller: directed bench with a recency-list cache model and an SRAM controller model.
module tb_cache_controller;
    logic        clk = 0, rst = 0;
    logic        mem_read_en = 0, mem_write_en = 0;
    logic [31:0] mem_address = 0, mem_write_data = 0;
    logic [31:0] mem_read_data, sram_address, sram_write_data, sram_read_data;
    logic        ready, sram_read_en, sram_write_en, sram_ready;
`ifdef CACHE_STATS_EN
    logic [15:0] hit_count, miss_count;
`endif

    int checks = 0, errors = 0;

    cache_controller dut (
        .clk             (clk),
        .rst             (rst),
        .mem_read_en     (mem_read_en),
        .mem_write_en    (mem_write_en),
        .mem_address     (mem_address),
        .mem_write_data  (mem_write_data),
        .mem_read_data   (mem_read_data),
        .ready           (ready),
        .sram_read_en    (sram_read_en),
        .sram_write_en   (sram_write_en),
        .sram_address    (sram_address),
        .sram_write_data (sram_write_data),
        .sram_read_data  (sram_read_data),
        .sram_ready      (sram_ready)
`ifdef CACHE_STATS_EN
        ,
        .hit_count       (hit_count),
        .miss_count      (miss_count)
`endif
    );

    always #5 clk = ~clk;

    // SRAM controller model: answers after the enable has been seen for 7 cycles.
    logic [31:0] smem [1024];
    int          scnt;
    assign sram_ready     = scnt == 7;
    assign sram_read_data = smem[sram_address[11:2]];
    always @(posedge clk or negedge rst) begin
        if (!rst)
            scnt <= 0;
        else if (sram_ready)
            scnt <= 0;
        else if (sram_read_en || sram_write_en)
            scnt <= scnt + 1;
    end
    always @(posedge clk)
        if (rst && sram_ready && sram_write_en)
            smem[sram_address[11:2]] = sram_write_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Cache model: per set a recency list, slot 0 most recently used.
    logic        mv [64][2];
    logic [9:0]  mt [64][2];
    logic [31:0] md [64][2];

    function automatic logic lookup(input logic [31:0] a, output logic [31:0] d, output int s);
        d = 0;
        s = 0;
        for (int k = 0; k < 2; k++)
            if (mv[a[7:2]][k] && mt[a[7:2]][k] == a[17:8]) begin
                d = md[a[7:2]][k];
                s = k;
                return 1'b1;
            end
        return 1'b0;
    endfunction

    function automatic void touch(input int set, input int s);
        if (s == 1) begin
            mv[set][1] = mv[set][0]; mv[set][0] = 1'b1;
            {mt[set][0], mt[set][1]} = {mt[set][1], mt[set][0]};
            {md[set][0], md[set][1]} = {md[set][1], md[set][0]};
        end
    endfunction

    function automatic void insert(input logic [31:0] a, input logic [31:0] d);
        mv[a[7:2]][1] = mv[a[7:2]][0];
        mt[a[7:2]][1] = mt[a[7:2]][0];
        md[a[7:2]][1] = md[a[7:2]][0];
        mv[a[7:2]][0] = 1'b1;
        mt[a[7:2]][0] = a[17:8];
        md[a[7:2]][0] = d;
    endfunction

    // Per-cycle compare: transaction-level expectations derived from the model.
    logic        busy = 0, kind_rd = 0;
    int          cyc = 0;
    logic [31:0] raddr = 0, rdat = 0;
    initial begin
        logic [31:0] d;
        logic        h;
        int          s;
        forever begin
            @(negedge clk);
            if (!rst) begin
                busy = 0;
                for (int i = 0; i < 64; i++) begin mv[i][0] = 0; mv[i][1] = 0; end
                chk("rst_ready", ready, 1);
                chk("rst_sram_read_en", sram_read_en, 0);
                chk("rst_sram_write_en", sram_write_en, 0);
                chk("rst_read_data", mem_read_data, 0);
            end else if (!busy) begin
                if (mem_read_en) begin
                    h = lookup(mem_address, d, s);
                    chk("rd_ready", ready, h);
                    chk("rd_sram_read_en", sram_read_en, !h);
                    chk("rd_sram_write_en", sram_write_en, 0);
                    chk("rd_data", mem_read_data, h ? d : 0);
                    if (h)
                        touch(mem_address[7:2], s);
                    else begin
                        chk("rd_sram_address", sram_address, mem_address);
                        busy = 1; kind_rd = 1; cyc = 1; raddr = mem_address;
                    end
                end else if (mem_write_en) begin
                    chk("wr_ready", ready, 0);
                    chk("wr_sram_read_en", sram_read_en, 0);
                    chk("wr_sram_write_en", sram_write_en, 1);
                    chk("wr_sram_address", sram_address, mem_address);
                    chk("wr_sram_write_data", sram_write_data, mem_write_data);
                    busy = 1; kind_rd = 0; cyc = 1; raddr = mem_address; rdat = mem_write_data;
                end else begin
                    chk("idle_ready", ready, 1);
                    chk("idle_sram_read_en", sram_read_en, 0);
                    chk("idle_sram_write_en", sram_write_en, 0);
                    chk("idle_read_data", mem_read_data, 0);
                end
            end else begin
                chk("busy_ready", ready, cyc == 7);
                chk("busy_sram_read_en", sram_read_en, kind_rd);
                chk("busy_sram_write_en", sram_write_en, !kind_rd);
                chk("busy_sram_address", sram_address, raddr);
                if (!kind_rd)
                    chk("busy_sram_write_data", sram_write_data, rdat);
                if (cyc == 7) begin
                    if (kind_rd) begin
                        d = smem[raddr[11:2]];
                        chk("fill_data", mem_read_data, d);
                        insert(raddr, d);
                    end else if (lookup(raddr, d, s)) begin
                        md[raddr[7:2]][s] = rdat;
                        touch(raddr[7:2], s);
                    end
                    busy = 0;
                end else
                    cyc++;
            end
        end
    end

    // One access: hold the request until ready, then one idle cycle.
    task automatic access(input logic r, input logic w, input logic [31:0] a, input logic [31:0] wd,
                          output int lat, output int sre, output int swe, output logic [31:0] rdata);
        logic ok = 0;
        lat = 0; sre = 0; swe = 0; rdata = 0;
        mem_read_en = r; mem_write_en = w; mem_address = a; mem_write_data = wd;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            sre += int'(sram_read_en);
            swe += int'(sram_write_en);
            if (ready) begin
                rdata = mem_read_data;
                ok = 1;
                break;
            end
            lat++;
        end
        if (!ok) chk("access_timeout", 0, 1);
        @(posedge clk); #1;
        mem_read_en = 0; mem_write_en = 0;
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int lat, sre, swe;
        logic [31:0] rd;
        logic ok;
        for (int i = 0; i < 1024; i++) smem[i] = 0;
        smem[32'h400 >> 2] = 32'hDEADBEEF;
        smem[32'h500 >> 2] = 32'h55555555;
        smem[32'h600 >> 2] = 32'h66666666;
        repeat (3) @(posedge clk);
        #1 rst = 1;
        @(posedge clk); #1;

        access(1, 0, 32'h400, 0, lat, sre, swe, rd);
        chk("s1_miss_latency", lat, 7);
        chk("s1_miss_sram_read_cycles", sre, 8);
        chk("s1_miss_data", rd, 32'hDEADBEEF);
        access(1, 0, 32'h400, 0, lat, sre, swe, rd);
        chk("s1_hit_latency", lat, 0);
        chk("s1_hit_no_sram", sre, 0);
        chk("s1_hit_data", rd, 32'hDEADBEEF);
`ifdef CACHE_STATS_EN
        chk("stats_hit_count", hit_count, 1);
        chk("stats_miss_count", miss_count, 1);
`endif

        access(0, 1, 32'h404, 32'h12345678, lat, sre, swe, rd);
        chk("s2_write_latency", lat, 7);
        chk("s2_write_en_cycles", swe, 8);
        access(1, 0, 32'h404, 0, lat, sre, swe, rd);
        chk("s2_no_allocate_latency", lat, 7);
        chk("s2_read_back", rd, 32'h12345678);

        access(0, 1, 32'h400, 32'hCAFEF00D, lat, sre, swe, rd);
        chk("s3_write_latency", lat, 7);
        access(1, 0, 32'h400, 0, lat, sre, swe, rd);
        chk("s3_hit_latency", lat, 0);
        chk("s3_hit_no_sram", sre, 0);
        chk("s3_hit_data", rd, 32'hCAFEF00D);

        access(1, 0, 32'h500, 0, lat, sre, swe, rd);
        chk("s4_fill_500", rd, 32'h55555555);
        access(1, 0, 32'h400, 0, lat, sre, swe, rd);
        chk("s4_touch_400", lat, 0);
        access(1, 0, 32'h600, 0, lat, sre, swe, rd);
        chk("s4_fill_600", lat, 7);
        access(1, 0, 32'h400, 0, lat, sre, swe, rd);
        chk("s4_400_kept", lat, 0);
        access(1, 0, 32'h500, 0, lat, sre, swe, rd);
        chk("s4_500_evicted", lat, 7);

        #1 rst = 0;
        @(posedge clk); #1 rst = 1;
        @(posedge clk); #1;
        mem_read_en = 1; mem_address = 32'h400;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        #1;
        chk("s5_reset_ready", ready, 1);
        chk("s5_reset_sram_read_en", sram_read_en, 0);
        @(posedge clk); #1 rst = 1;
        #1;
        chk("s5_remiss_sram_read_en", sram_read_en, 1);
        chk("s5_remiss_ready", ready, 0);
        ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (ready) begin
                ok = 1;
                chk("s5_refill_data", mem_read_data, 32'hCAFEF00D);
            end
        end
        if (!ok) chk("s5_timeout", 0, 1);
        @(posedge clk); #1 mem_read_en = 0;
        repeat (2) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
